// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared defaults, capture-window helper and drain FSM state type
//             for the systolic array output collector.
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Array geometry defaults
    localparam int DEF_DW   = 32;
    localparam int DEF_COLS = 3;
    localparam int DEF_ROWS = 3;

    // Last edge index k of a tile capture: the edge that aligns row ROWS-1
    function automatic int cap_last(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    localparam int CAP_LAST = cap_last(DEF_ROWS, DEF_COLS);

    // Drain controller states
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO, registered head (no write-to-read bypass).
//             When full, a pop frees its slot before a same-edge push lands.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the same edge pops
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; cleared on reset so the head reads a defined value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_drain.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_drain
//  Purpose  : Output collector for the weight-stationary systolic array.
//             Deskews the diagonally arriving south outputs, packs each
//             result row into one word and queues rows for a valid/ready
//             consumer.
//  Options  : SYSTOLIC_DRAIN_ROW_IDX_EN - adds out_row, the row index stored
//             alongside each queued row.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_drain
    import systolic_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int COLS  = DEF_COLS,
    parameter  int ROWS  = DEF_ROWS,
    parameter  int DEPTH = 4,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COLS*DW-1:0] in_south,
    output logic [COLS*DW-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
    output logic [ROW_W-1:0]   out_row,
`endif
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    // Capture window: edges k = 0 .. c_CAP_LAST, first push at k = COLS-1
    localparam int                 c_CAP_LAST  = cap_last(ROWS, COLS);
    localparam int                 c_CNT_W     = (c_CAP_LAST > 0) ? $clog2(c_CAP_LAST + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_CAP_LAST);
    localparam logic [c_CNT_W-1:0] c_CNT_FIRST = c_CNT_W'(COLS - 1);

`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
    localparam int c_FW = COLS*DW + ROW_W;
`else
    localparam int c_FW = COLS*DW;
`endif

    drain_state_t        r_state;
    drain_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_k;
    logic                w_in_tile;
    logic                w_push;
    logic                w_done_nxt;
    logic                r_done;
    logic                r_overflow;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [COLS*DW-1:0]  w_aligned;
    logic [c_FW-1:0]     w_fifo_in;
    logic [c_FW-1:0]     w_fifo_out;

    // ------------------------------------------------------------------
    // Deskew: column c is delayed COLS-1-c cycles so every column of one
    // row reaches the packer on the same edge.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int c_STAGES = COLS - 1 - c;
        if (c_STAGES == 0) begin : g_pass
            assign w_aligned[c*DW +: DW] = in_south[c*DW +: DW];
        end else begin : g_chain
            logic [DW-1:0] r_pipe [c_STAGES];

            // Free-running shift chain for this column
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < c_STAGES; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= in_south[c*DW +: DW];
                    for (int i = 1; i < c_STAGES; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_aligned[c*DW +: DW] = r_pipe[c_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Capture controller. r_cnt holds the k of the most recent edge of the
    // tile; w_k is the k of the upcoming edge. A start arriving on the
    // edge after k = c_CAP_LAST chains straight into a new tile.
    // ------------------------------------------------------------------

    // State, edge counter and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, edge index and push decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k         = '0;
        w_in_tile   = 1'b0;
        if (r_state == CAPTURE && r_cnt != c_CNT_LAST) begin
            w_in_tile = 1'b1;
            w_k       = r_cnt + c_CNT_W'(1);
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end else if (start) begin
            w_in_tile   = 1'b1;
            w_k         = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = CAPTURE;
        end else begin
            w_state_nxt = IDLE;
        end
        w_push     = w_in_tile && (w_k >= c_CNT_FIRST);
        w_done_nxt = w_in_tile && (w_k == c_CNT_LAST);
    end

    assign busy = (r_state == CAPTURE);
    assign done = r_done;

    // ------------------------------------------------------------------
    // Row queue
    // ------------------------------------------------------------------
    // A push is lost only when full and nothing leaves on the same edge
    assign w_drop = w_push && w_full && !out_ready;

    // Sticky drop flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign out_valid = !w_empty;

`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
    logic [ROW_W-1:0] w_row;
    // Row being aligned on this edge is k-(COLS-1)
    assign w_row     = ROW_W'(w_k - c_CNT_FIRST);
    assign w_fifo_in = {w_row, w_aligned};
    assign out_data  = w_fifo_out[COLS*DW-1:0];
    assign out_row   = w_fifo_out[c_FW-1 -: ROW_W];
`else
    assign w_fifo_in = w_aligned;
    assign out_data  = w_fifo_out;
`endif

    sync_fifo #(
        .WIDTH (c_FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (out_ready),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_drain
//  Purpose  : Self-checking bench for systolic_drain against a timing-rule
//             reference model (tile schedule plus bounded row queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_drain;

    localparam int DW       = 32;
    localparam int COLS     = 3;
    localparam int ROWS     = 3;
    localparam int DEPTH    = 4;
    localparam int CAP_LAST = ROWS + COLS - 2;
    localparam int MAXT     = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [COLS*DW-1:0] in_south;
    logic [COLS*DW-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               overflow;
`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
    logic [1:0]         out_row;
`endif

    systolic_drain #(
        .DW    (DW),
        .COLS  (COLS),
        .ROWS  (ROWS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_south  (in_south),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
        .out_row   (out_row),
`endif
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_err = 0;
    int n_chk = 0;

    // Reference model state
    int                 edge_n;
    int                 ntiles;
    int                 tstart [MAXT];
    bit                 tlive  [MAXT];
    logic [DW-1:0]      tmem   [MAXT][ROWS][COLS];
    logic [COLS*DW-1:0] mq_data[$];
    int                 mq_row [$];
    bit                 m_ovf;
    bit                 m_busy;
    bit                 m_done;
    bit                 pattern_mode;
    int                 busy_cnt;
    int                 done_edges[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge
    task automatic step(input bit st_req, input bit rdy);
        int                 e;
        int                 r;
        bit                 st;
        logic [COLS*DW-1:0] din;
        logic [COLS*DW-1:0] row;
        e  = edge_n;
        st = st_req && (ntiles < MAXT);
        // A start is taken unless a live tile is in edges 1..CAP_LAST of its window
        if (st) begin
            bit acc;
            acc = 1'b1;
            for (int t = 0; t < ntiles; t++) begin
                if (tlive[t] && e >= tstart[t] + 1 && e <= tstart[t] + CAP_LAST) acc = 1'b0;
            end
            if (acc) begin
                tstart[ntiles] = e;
                tlive[ntiles]  = 1'b1;
                for (int rr = 0; rr < ROWS; rr++) begin
                    for (int c = 0; c < COLS; c++) begin
                        tmem[ntiles][rr][c] = pattern_mode ? DW'(32'h100 * rr + c) : DW'($urandom);
                    end
                end
                ntiles++;
            end
        end
        for (int c = 0; c < COLS; c++) din[c*DW +: DW] = DW'($urandom);
        for (int t = 0; t < ntiles; t++) begin
            if (tlive[t]) begin
                for (int c = 0; c < COLS; c++) begin
                    r = e - tstart[t] - c;
                    if (r >= 0 && r < ROWS) din[c*DW +: DW] = tmem[t][r][c];
                end
            end
        end
        start     = st;
        out_ready = rdy;
        in_south  = din;

        // Queue: pop (if something visible) happens before the push
        if (rdy && mq_data.size() > 0) begin
            void'(mq_data.pop_front());
            void'(mq_row.pop_front());
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        for (int t = 0; t < ntiles; t++) begin
            if (tlive[t]) begin
                r = e - tstart[t] - (COLS - 1);
                if (r >= 0 && r < ROWS) begin
                    for (int c = 0; c < COLS; c++) row[c*DW +: DW] = tmem[t][r][c];
                    if (mq_data.size() < DEPTH) begin
                        mq_data.push_back(row);
                        mq_row.push_back(r);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (e >= tstart[t] && e <= tstart[t] + CAP_LAST) m_busy = 1'b1;
                if (e == tstart[t] + CAP_LAST) m_done = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        edge_n++;
        if (busy) busy_cnt++;
        if (done) done_edges.push_back(e);
        check("out_valid", out_valid, mq_data.size() > 0);
        if (mq_data.size() > 0) begin
            check("out_data", out_data, mq_data[0]);
`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
            check("out_row", out_row, mq_row[0]);
`endif
        end
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic mid_reset();
        start = 1'b0;
        rst   = 1'b1;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
`ifdef SYSTOLIC_DRAIN_ROW_IDX_EN
        check("rst_row", out_row, 2'd0);
`endif
        rst = 1'b0;
        mq_data.delete();
        mq_row.delete();
        for (int t = 0; t < ntiles; t++) tlive[t] = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        out_ready    = 1'b0;
        in_south     = '0;
        ntiles       = 0;
        m_ovf        = 1'b0;
        pattern_mode = 1'b1;
        for (int t = 0; t < MAXT; t++) tlive[t] = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        rst    = 1'b0;
        edge_n = 0;

        // Basic tile with the 0x100*r+c pattern
        busy_cnt = 0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("basic_row0", out_data, {32'h2, 32'h1, 32'h0});
        step(1'b0, 1'b1);
        check("basic_row1", out_data, {32'h102, 32'h101, 32'h100});
        step(1'b0, 1'b1);
        check("basic_row2", out_data, {32'h202, 32'h201, 32'h200});
        check("basic_done", done, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        check("basic_busy_cycles", busy_cnt, 5);
        pattern_mode = 1'b0;

        // Start while busy is ignored
        done_edges.delete();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check("swb_done_pulses", done_edges.size(), 1);

        // Back-to-back tiles: second start on the edge busy drops
        done_edges.delete();
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check("b2b_done_pulses", done_edges.size(), 2);
        if (done_edges.size() == 2) check("b2b_done_gap", done_edges[1] - done_edges[0], 5);

        // Full FIFO with a pop on the same edge as a push
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("full_valid", out_valid, 1'b1);
        step(1'b0, 1'b1);
        check("full_pop_no_ovf", overflow, 1'b0);
        repeat (8) step(1'b0, 1'b1);

        // Reset with one row buffered, then a clean tile
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        mid_reset();
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);

        // Backpressure across two tiles: six pushes into four slots
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        check("bp_overflow", overflow, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check("bp_drained", out_valid, 1'b0);

        // Random traffic
        repeat (60) step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        repeat (10) step(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
